ahb_slave_if: RTL and testbench

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

---
 rtl/ahb_bridge_pkg.sv | 69 ++++++
 rtl/ahb_burst_tracker.sv | 94 +++++++++
 rtl/ahb_slave_if.sv | 131 +++++++++++++
 tb/tb_ahb_slave_if.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_bridge_pkg.sv
// Shared AHB bridge types, slot constants and the burst next-address helper.
package ahb_bridge_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    RespOkay  = 2'b00,
    RespError = 2'b01
  } hresp_t;

  typedef enum logic {
    B_IDLE   = 1'b0,
    B_ACTIVE = 1'b1
  } burst_state_t;

  typedef enum logic [1:0] {
    E_IDLE = 2'b00,
    E_ERR1 = 2'b01,
    E_ERR2 = 2'b10
  } err_state_t;

  localparam int unsigned NumSlots        = 3;
  localparam logic [31:0] DefaultBaseAddr = 32'h8000_0000;
  localparam logic [31:0] DefaultSlotSize = 32'h0400_0000;
  localparam logic [2:0]  Slot0Sel        = 3'b001;
  localparam logic [2:0]  Slot1Sel        = 3'b010;
  localparam logic [2:0]  Slot2Sel        = 3'b100;
  localparam logic [2:0]  NoSlotSel       = 3'b000;

  // Beats left after the first one; zero for SINGLE/INCR (untracked lengths).
  function automatic logic [3:0] burst_remaining(hburst_t b);
    case (b)
      BurstWrap4,  BurstIncr4:  return 4'd3;
      BurstWrap8,  BurstIncr8:  return 4'd7;
      BurstWrap16, BurstIncr16: return 4'd15;
      default:                  return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] burst_next(logic [31:0] addr, logic [2:0] size, hburst_t b);
    logic [31:0] inc;
    logic [31:0] sum;
    logic [31:0] mask;
    inc  = 32'd1 << size;
    sum  = addr + inc;
    mask = (({28'd0, burst_remaining(b)} + 32'd1) << size) - 32'd1;
    if (b == BurstWrap4 || b == BurstWrap8 || b == BurstWrap16) begin
      return (addr & ~mask) | (sum & mask);
    end
    return sum;
  endfunction

endpackage

// File: rtl/ahb_burst_tracker.sv
// Fixed-length AHB burst checker: flags SEQ beats whose address or sequencing is wrong.
module ahb_burst_tracker
  import ahb_bridge_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hburst,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  output logic        burst_err
);

  burst_state_t r_state, w_state_d;
  hburst_t      r_burst, w_burst_d;
  logic [3:0]   r_remaining, w_remaining_d;
  logic [31:0]  r_expected, w_expected_d;
  logic [2:0]   r_size, w_size_d;
  logic         r_incr, w_incr_d;
  logic         r_burst_err, w_err_d;
  htrans_t      w_trans;
  hburst_t      w_hburst;

  assign w_trans   = htrans_t'(Htrans);
  assign w_hburst  = hburst_t'(Hburst);
  assign burst_err = r_burst_err;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_state     <= B_IDLE;
      r_burst     <= BurstSingle;
      r_remaining <= 4'd0;
      r_expected  <= 32'd0;
      r_size      <= 3'd0;
      r_incr      <= 1'b0;
      r_burst_err <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_burst     <= w_burst_d;
      r_remaining <= w_remaining_d;
      r_expected  <= w_expected_d;
      r_size      <= w_size_d;
      r_incr      <= w_incr_d;
      r_burst_err <= w_err_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_burst_d     = r_burst;
    w_remaining_d = r_remaining;
    w_expected_d  = r_expected;
    w_size_d      = r_size;
    w_incr_d      = r_incr;
    w_err_d       = 1'b0;
    if (Hreadyin) begin
      case (w_trans)
        TransNonseq: begin
          // A NONSEQ always restarts tracking, even mid-burst (early termination).
          w_incr_d = (w_hburst == BurstIncr);
          if (burst_remaining(w_hburst) != 4'd0) begin
            w_state_d     = B_ACTIVE;
            w_burst_d     = w_hburst;
            w_size_d      = Hsize;
            w_remaining_d = burst_remaining(w_hburst);
            w_expected_d  = burst_next(Haddr, Hsize, w_hburst);
          end else begin
            w_state_d = B_IDLE;
          end
        end
        TransSeq: begin
          if (r_state == B_ACTIVE) begin
            w_err_d       = (Haddr != r_expected);
            w_expected_d  = burst_next(r_expected, r_size, r_burst);
            w_remaining_d = r_remaining - 4'd1;
            if (r_remaining == 4'd1) begin
              w_state_d = B_IDLE;
            end
          end else begin
            w_err_d = !r_incr;
          end
        end
        TransIdle: begin
          w_err_d   = (r_state == B_ACTIVE);
          w_state_d = B_IDLE;
          w_incr_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB slave side of the AHB-to-APB bridge: window decode, address/data pipeline, burst checks.
// Define AHB_SLV_ERR_RESP_EN to answer out-of-window transfers with a two-cycle ERROR response.
module ahb_slave_if
  import ahb_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DefaultBaseAddr,
  parameter logic [31:0] SLOT_SIZE = DefaultSlotSize
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [2:0]  tempselx,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        err_hready,
  output logic        burst_err
);

  localparam logic [32:0] SlotSize33 = {1'b0, SLOT_SIZE};
  localparam logic [32:0] TwoSlots   = SlotSize33 * 33'd2;
  localparam logic [32:0] WindowSize = SlotSize33 * 33'd3;

  logic [32:0] w_offset;
  logic        w_in_window;
  logic [31:0] r_haddr1, r_haddr2, r_hwdata1, r_hwdata2;
  logic        r_hwritereg;

  // Bit 32 of the 33-bit difference is set when Haddr lies below the window.
  assign w_offset    = {1'b0, Haddr} - {1'b0, BASE_ADDR};
  assign w_in_window = !w_offset[32] && (w_offset < WindowSize);

  assign valid     = Hreadyin && Htrans[1] && w_in_window;
  assign Hrdata    = Prdata;
  assign Haddr1    = r_haddr1;
  assign Haddr2    = r_haddr2;
  assign Hwdata1   = r_hwdata1;
  assign Hwdata2   = r_hwdata2;
  assign Hwritereg = r_hwritereg;

  always_comb begin
    tempselx = NoSlotSel;
    if (w_in_window) begin
      if (w_offset < SlotSize33) begin
        tempselx = Slot0Sel;
      end else if (w_offset < TwoSlots) begin
        tempselx = Slot1Sel;
      end else begin
        tempselx = Slot2Sel;
      end
    end
  end

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_haddr1    <= 32'd0;
      r_haddr2    <= 32'd0;
      r_hwdata1   <= 32'd0;
      r_hwdata2   <= 32'd0;
      r_hwritereg <= 1'b0;
    end else if (Hreadyin) begin
      r_haddr1    <= Haddr;
      r_haddr2    <= r_haddr1;
      r_hwdata1   <= Hwdata;
      r_hwdata2   <= r_hwdata1;
      r_hwritereg <= Hwrite;
    end
  end

  ahb_burst_tracker u_burst_tracker (
    .Hclk      (Hclk),
    .Hreset    (Hreset),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Hburst    (Hburst),
    .Hsize     (Hsize),
    .Haddr     (Haddr),
    .burst_err (burst_err)
  );

`ifdef AHB_SLV_ERR_RESP_EN
  err_state_t r_err_state, w_err_state_d;

  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      r_err_state <= E_IDLE;
    end else begin
      r_err_state <= w_err_state_d;
    end
  end

  always_comb begin
    w_err_state_d = r_err_state;
    Hresp         = RespOkay;
    err_hready    = 1'b1;
    unique case (r_err_state)
      E_IDLE: begin
        if (Hreadyin && Htrans[1] && !w_in_window) begin
          w_err_state_d = E_ERR1;
        end
      end
      E_ERR1: begin
        Hresp         = RespError;
        err_hready    = 1'b0;
        w_err_state_d = E_ERR2;
      end
      E_ERR2: begin
        Hresp         = RespError;
        w_err_state_d = E_IDLE;
      end
      default: w_err_state_d = E_IDLE;
    endcase
  end
`else
  assign Hresp      = RespOkay;
  assign err_hready = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: reference model compared every cycle plus literal spot checks.
module tb_ahb_slave_if;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        Hwrite = 1'b0;
  logic        Hreadyin = 1'b0;
  logic [1:0]  Htrans = 2'b00;
  logic [2:0]  Hsize = 3'd2;
  logic [2:0]  Hburst = 3'd0;
  logic [31:0] Haddr = 32'd0;
  logic [31:0] Hwdata = 32'd0;
  logic [31:0] Prdata = 32'd0;
  logic        valid, Hwritereg, err_hready, burst_err;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [2:0]  tempselx;
  logic [1:0]  Hresp;

  int errors = 0;
  int checks = 0;
  logic comp_en = 1'b0;

  always #5 Hclk = ~Hclk;

  ahb_slave_if dut (
    .Hclk       (Hclk),
    .Hreset     (Hreset),
    .Hwrite     (Hwrite),
    .Hreadyin   (Hreadyin),
    .Htrans     (Htrans),
    .Hsize      (Hsize),
    .Hburst     (Hburst),
    .Haddr      (Haddr),
    .Hwdata     (Hwdata),
    .Prdata     (Prdata),
    .valid      (valid),
    .Haddr1     (Haddr1),
    .Haddr2     (Haddr2),
    .Hwdata1    (Hwdata1),
    .Hwdata2    (Hwdata2),
    .Hwritereg  (Hwritereg),
    .tempselx   (tempselx),
    .Hrdata     (Hrdata),
    .Hresp      (Hresp),
    .err_hready (err_hready),
    .burst_err  (burst_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_win(input logic [31:0] a);
    return (a >= 32'h8000_0000) && (a < 32'h8C00_0000);
  endfunction

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    logic [31:0] slot;
    if (!in_win(a)) return 3'b000;
    slot = (a - 32'h8000_0000) / 32'h0400_0000;
    return 3'b001 << slot;
  endfunction

  function automatic int beats_of(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 0;
    endcase
  endfunction

  // Address of beat i of a burst starting at a.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                            input logic [2:0] b, input int i);
    logic [31:0] inc, total, lo;
    inc   = 32'd1 << sz;
    total = beats_of(b) * inc;
    if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
      lo = a - (a % total);
      return lo + ((a - lo + i * inc) % total);
    end
    return a + i * inc;
  endfunction

  logic [31:0] m_haddr1 = 0, m_haddr2 = 0, m_hwdata1 = 0, m_hwdata2 = 0;
  logic        m_hwritereg = 0, m_burst_err = 0, m_incr = 0;
  int          m_err_phase = 0;
  logic [31:0] m_exp[$];

  always @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      m_haddr1 = 0; m_haddr2 = 0; m_hwdata1 = 0; m_hwdata2 = 0;
      m_hwritereg = 0; m_burst_err = 0; m_incr = 0; m_err_phase = 0;
      m_exp.delete();
    end else begin
      if (m_err_phase > 0) m_err_phase--;
      else if (Hreadyin && Htrans[1] && !in_win(Haddr)) m_err_phase = 2;
      m_burst_err = 0;
      if (Hreadyin) begin
        m_haddr2 = m_haddr1; m_haddr1 = Haddr;
        m_hwdata2 = m_hwdata1; m_hwdata1 = Hwdata;
        m_hwritereg = Hwrite;
        case (Htrans)
          NS: begin
            m_exp.delete();
            m_incr = (Hburst == 3'd1);
            for (int i = 1; i < beats_of(Hburst); i++) m_exp.push_back(beat_addr(Haddr, Hsize, Hburst, i));
          end
          SQ: begin
            if (m_exp.size() > 0) begin
              if (Haddr != m_exp[0]) m_burst_err = 1;
              void'(m_exp.pop_front());
            end else if (!m_incr) begin
              m_burst_err = 1;
            end
          end
          ID: begin
            if (m_exp.size() > 0) m_burst_err = 1;
            m_exp.delete();
            m_incr = 0;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge Hclk) begin
    if (comp_en) begin
      check("valid", {31'd0, valid}, {31'd0, Hreadyin && Htrans[1] && in_win(Haddr)});
      check("tempselx", {29'd0, tempselx}, {29'd0, exp_sel(Haddr)});
      check("Hrdata", Hrdata, Prdata);
      check("Haddr1", Haddr1, m_haddr1);
      check("Haddr2", Haddr2, m_haddr2);
      check("Hwdata1", Hwdata1, m_hwdata1);
      check("Hwdata2", Hwdata2, m_hwdata2);
      check("Hwritereg", {31'd0, Hwritereg}, {31'd0, m_hwritereg});
      check("burst_err", {31'd0, burst_err}, {31'd0, m_burst_err});
`ifdef AHB_SLV_ERR_RESP_EN
      check("Hresp", {30'd0, Hresp}, (m_err_phase > 0) ? 32'd1 : 32'd0);
      check("err_hready", {31'd0, err_hready}, (m_err_phase == 2) ? 32'd0 : 32'd1);
`else
      check("Hresp", {30'd0, Hresp}, 32'd0);
      check("err_hready", {31'd0, err_hready}, 32'd1);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [1:0] tr, input logic [31:0] a, input logic [2:0] b = 3'd0,
                      input logic rdy = 1'b1, input logic wr = 1'b0);
    @(posedge Hclk);
    #1;
    Htrans = tr; Haddr = a; Hburst = b; Hreadyin = rdy; Hwrite = wr; Hsize = 3'd2;
    Hwdata = $urandom; Prdata = $urandom;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Hreset = 1'b1;
    repeat (2) @(posedge Hclk);
    #1;
    check("rst Haddr1", Haddr1, 32'd0);
    check("rst Hwritereg", {31'd0, Hwritereg}, 32'd0);
    check("rst burst_err", {31'd0, burst_err}, 32'd0);
    check("rst Hresp", {30'd0, Hresp}, 32'd0);
    check("rst err_hready", {31'd0, err_hready}, 32'd1);
    comp_en = 1'b1;
    Hreset = 1'b0;

    // Single write to slot 1 and pipeline progression.
    step(NS, 32'h8400_0010, 3'd0, 1'b1, 1'b1);
    #1;
    check("lit valid", {31'd0, valid}, 32'd1);
    check("lit tempselx", {29'd0, tempselx}, 32'd2);
    step(ID, 32'd0);
    check("lit Haddr1", Haddr1, 32'h8400_0010);
    check("lit Hwritereg", {31'd0, Hwritereg}, 32'd1);
    step(ID, 32'd0);
    check("lit Haddr2", Haddr2, 32'h8400_0010);

    // INCR4 with a BUSY beat, then an extra SEQ once the burst has completed.
    step(NS, 32'h8000_0000, 3'd3);
    step(SQ, 32'h8000_0004, 3'd3);
    step(BZ, 32'h8000_0008, 3'd3);
    step(SQ, 32'h8000_0008, 3'd3);
    step(SQ, 32'h8000_000C, 3'd3);
    step(SQ, 32'h8000_0010, 3'd3);
    check("lit incr4 no err", {31'd0, burst_err}, 32'd0);
    step(ID, 32'd0);
    check("lit seq after burst", {31'd0, burst_err}, 32'd1);

    // WRAP4 good then bad.
    step(NS, 32'h8000_0008, 3'd2);
    step(SQ, 32'h8000_000C, 3'd2);
    step(SQ, 32'h8000_0000, 3'd2);
    step(SQ, 32'h8000_0004, 3'd2);
    step(ID, 32'd0);
    check("lit wrap4 ok", {31'd0, burst_err}, 32'd0);
    step(NS, 32'h8000_0008, 3'd2);
    step(SQ, 32'h8000_000C, 3'd2);
    step(SQ, 32'h8000_0010, 3'd2);
    step(SQ, 32'h8000_0004, 3'd2);
    check("lit wrap4 bad", {31'd0, burst_err}, 32'd1);
    step(ID, 32'd0);
    check("lit wrap4 pulse end", {31'd0, burst_err}, 32'd0);

    // INCR tolerates SEQ; SINGLE does not; NONSEQ mid-burst is silent.
    step(NS, 32'h8000_0300, 3'd1);
    step(SQ, 32'h8000_0500, 3'd1);
    step(NS, 32'h8000_0400, 3'd0);
    check("lit incr seq", {31'd0, burst_err}, 32'd0);
    step(SQ, 32'h8000_0404, 3'd0);
    step(NS, 32'h8800_0000, 3'd7);
    check("lit single seq", {31'd0, burst_err}, 32'd1);
    step(SQ, 32'h8800_0004, 3'd7);
    step(NS, 32'h8800_0100, 3'd0);
    step(ID, 32'd0);
    check("lit early term", {31'd0, burst_err}, 32'd0);

    // Out-of-window transfer.
    step(NS, 32'h9000_0000, 3'd0);
    #1;
    check("lit oow valid", {31'd0, valid}, 32'd0);
    check("lit oow tempselx", {29'd0, tempselx}, 32'd0);
    step(ID, 32'd0);
`ifdef AHB_SLV_ERR_RESP_EN
    check("lit err1 Hresp", {30'd0, Hresp}, 32'd1);
    check("lit err1 hready", {31'd0, err_hready}, 32'd0);
    step(ID, 32'd0);
    check("lit err2 Hresp", {30'd0, Hresp}, 32'd1);
    check("lit err2 hready", {31'd0, err_hready}, 32'd1);
`else
    check("lit oow Hresp", {30'd0, Hresp}, 32'd0);
    check("lit oow hready", {31'd0, err_hready}, 32'd1);
    step(ID, 32'd0);
`endif
    step(ID, 32'd0);
    check("lit err done", {30'd0, Hresp}, 32'd0);

    // Reset during beat 2 of INCR8.
    step(NS, 32'h8000_0100, 3'd5, 1'b1, 1'b1);
    step(SQ, 32'h8000_0104, 3'd5);
    #2;
    Hreset = 1'b1;
    #1;
    check("lit midrst Haddr1", Haddr1, 32'd0);
    check("lit midrst Hwritereg", {31'd0, Hwritereg}, 32'd0);
    @(posedge Hclk);
    #1;
    Htrans = ID;
    Hreset = 1'b0;
    step(SQ, 32'h8000_0108, 3'd5);
    check("lit no residual", {31'd0, burst_err}, 32'd0);
    step(ID, 32'd0);
    check("lit seq after rst", {31'd0, burst_err}, 32'd1);

    // Stall for three cycles mid-burst.
    step(NS, 32'h8000_0200, 3'd3);
    step(SQ, 32'h8000_0204, 3'd3);
    for (int k = 0; k < 3; k++) step(SQ, 32'h1234_5670 + 32'(k * 8), 3'd3, 1'b0);
    step(SQ, 32'h8000_0208, 3'd3);
    check("lit stall Haddr1", Haddr1, 32'h8000_0204);
    check("lit stall Haddr2", Haddr2, 32'h8000_0200);
    step(SQ, 32'h8000_020C, 3'd3);
    step(ID, 32'd0);
    check("lit stall no err", {31'd0, burst_err}, 32'd0);
    step(ID, 32'd0);
    step(ID, 32'd0);

    @(posedge Hclk);
    #1;
    comp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
